// File: rtl/da_pkg.sv
// Shared constants, FSM encoding and helper function for the DA FIR engine.
// Optional build macro used by this slice: DA_PIPE_TREE_EN.
package da_pkg;

  localparam int DA_NBANK  = 8;
  localparam int DA_ADDR_W = 8;
  localparam int DA_COEF_W = 20;
  localparam int DA_IN_W   = 16;
  localparam int DA_ACC_W  = 38;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } da_state_t;

  // Ceiling log2, usable in constant expressions (port widths, localparams).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/da_adder_tree.sv
// Balanced signed reduction of NBANK LUT outputs; registered output when
// DA_PIPE_TREE_EN is defined, purely combinational otherwise.
module da_adder_tree
  import da_pkg::*;
#(
  parameter int NBANK  = DA_NBANK,
  parameter int COEF_W = DA_COEF_W
) (
`ifdef DA_PIPE_TREE_EN
  input  logic                              clk,
  input  logic                              resetn,
`endif
  input  logic [NBANK*COEF_W-1:0]           terms,
  output logic [COEF_W+clog2(NBANK)-1:0]    sum
);

  localparam int OUT_W = COEF_W + clog2(NBANK);

  // Heap layout: leaves at NBANK-1..2*NBANK-2, node i sums its two children.
  logic signed [OUT_W-1:0] node [2*NBANK-1];

  always_comb begin
    for (int i = 0; i < NBANK; i++) begin
      node[NBANK-1+i] = OUT_W'($signed(terms[i*COEF_W +: COEF_W]));
    end
    for (int i = NBANK - 2; i >= 0; i--) begin
      node[i] = node[2*i+1] + node[2*i+2];
    end
  end

`ifdef DA_PIPE_TREE_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sum <= '0;
    end else begin
      sum <= node[0];
    end
  end
`else
  assign sum = node[0];
`endif

endmodule

// File: rtl/da_engine.sv
// Bit-serial distributed-arithmetic FIR engine: tap delay line, per-bank LUTs,
// adder tree and shift-accumulator. DA_PIPE_TREE_EN adds one tree pipe stage.
module da_engine
  import da_pkg::*;
#(
  parameter int NBANK  = DA_NBANK,
  parameter int ADDR_W = DA_ADDR_W,
  parameter int COEF_W = DA_COEF_W,
  parameter int IN_W   = DA_IN_W,
  parameter int ACC_W  = DA_ACC_W
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [IN_W-1:0]                 x_in,
  input  logic                            x_valid,
  output logic                            x_ready,
  input  logic                            cload,
  input  logic [clog2(NBANK)+ADDR_W-1:0]  caddr,
  input  logic [COEF_W-1:0]               cin,
  output logic [ACC_W-1:0]                y,
  output logic                            y_valid,
  output logic                            busy
);

  localparam int TAPS   = NBANK * ADDR_W;
  localparam int BANK_W = clog2(NBANK);
  localparam int TREE_W = COEF_W + BANK_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int POS_W  = clog2(IN_W);
  localparam int CNT_W  = POS_W + 1;
`ifdef DA_PIPE_TREE_EN
  localparam int PIPE   = 1;
`else
  localparam int PIPE   = 0;
`endif
  localparam int RUN_LEN = IN_W + PIPE;

  da_state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [IN_W-1:0]   dline [TAPS];
  logic [COEF_W-1:0] lut [NBANK][DEPTH];
  logic [ADDR_W-1:0] bank_addr [NBANK];
  logic [POS_W-1:0]  bit_pos;

  logic [NBANK*COEF_W-1:0] tree_in;
  logic [TREE_W-1:0]       tree_sum;

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_nxt;
  logic [ACC_W-1:0] s_ext;
  logic [ACC_W-1:0] y_q;
  logic             y_valid_q;

  logic accept;
  logic lut_we;
  logic last_iter;
  logic first_iter;
  logic acc_en;

  assign x_ready = (state_q == IDLE) && !cload;
  assign accept  = x_valid && x_ready;
  assign lut_we  = cload && (state_q == IDLE);
  assign busy    = (state_q != IDLE);
  assign y       = y_q;
  assign y_valid = y_valid_q;

  assign last_iter = (state_q == RUN) && (cnt_q == CNT_W'(RUN_LEN - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt_q == CNT_W'(RUN_LEN - 1)) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // LUT storage has no reset; software reloads it after power-up.
  always_ff @(posedge clk) begin
    if (lut_we) begin
      lut[caddr[ADDR_W+BANK_W-1:ADDR_W]][caddr[ADDR_W-1:0]] <= cin;
    end
  end

  // MSB first; in the piped build the final fill cycle wraps harmlessly.
  assign bit_pos = POS_W'(IN_W - 1) - cnt_q[POS_W-1:0];

  always_comb begin
    for (int b = 0; b < NBANK; b++) begin
      bank_addr[b] = '0;
      for (int j = 0; j < ADDR_W; j++) begin
        bank_addr[b][j] = dline[b*ADDR_W+j][bit_pos];
      end
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    assign tree_in[b*COEF_W +: COEF_W] = lut[b][bank_addr[b]];
  end

  da_adder_tree #(
    .NBANK  (NBANK),
    .COEF_W (COEF_W)
  ) u_tree (
`ifdef DA_PIPE_TREE_EN
    .clk    (clk),
    .resetn (resetn),
`endif
    .terms  (tree_in),
    .sum    (tree_sum)
  );

  // The first accumulated bit is the sample sign bit and carries negative weight.
  assign s_ext      = ACC_W'($signed(tree_sum));
  assign first_iter = (cnt_q == CNT_W'(PIPE));
  assign acc_en     = (state_q == RUN) && ((PIPE == 0) || (cnt_q != '0));
  assign acc_nxt    = first_iter ? (ACC_W'(0) - s_ext) : ((acc_q << 1) + s_ext);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        dline[i] <= '0;
      end
    end else begin
      y_valid_q <= 1'b0;
      if (accept) begin
        cnt_q    <= '0;
        dline[0] <= x_in;
        for (int i = 1; i < TAPS; i++) begin
          dline[i] <= dline[i-1];
        end
      end else if (state_q == RUN) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (acc_en) begin
        acc_q <= acc_nxt;
      end
      // Result lands as the FSM enters FLUSH so y and y_valid appear together.
      if (last_iter) begin
        y_q       <= acc_nxt;
        y_valid_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_da_engine.sv
// Directed self-checking bench for da_engine; expected latency follows
// DA_PIPE_TREE_EN when the bench is built with that macro.
module tb_da_engine;

  localparam int NBANK  = 8;
  localparam int ADDR_W = 8;
  localparam int COEF_W = 20;
  localparam int IN_W   = 16;
  localparam int ACC_W  = 38;
`ifdef DA_PIPE_TREE_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif

  logic                    clk;
  logic                    resetn;
  logic [IN_W-1:0]         x_in;
  logic                    x_valid;
  logic                    x_ready;
  logic                    cload;
  logic [3+ADDR_W-1:0]     caddr;
  logic [COEF_W-1:0]       cin;
  logic [ACC_W-1:0]        y;
  logic                    y_valid;
  logic                    busy;

  int errors = 0;
  int checks = 0;

  da_engine #(
    .NBANK  (NBANK),
    .ADDR_W (ADDR_W),
    .COEF_W (COEF_W),
    .IN_W   (IN_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .x_in    (x_in),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .cload   (cload),
    .caddr   (caddr),
    .cin     (cin),
    .y       (y),
    .y_valid (y_valid),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic writeLut(input int bank, input int entry, input int value);
    @(negedge clk);
    cload = 1'b1;
    caddr = 11'((bank << ADDR_W) | entry);
    cin   = 20'(value);
    @(negedge clk);
    cload = 1'b0;
  endtask

  // Pushes one sample and checks latency, result and return to IDLE.
  // With poke set, a LUT write is attempted in the middle of RUN.
  task automatic applyStimulus(input logic signed [15:0] x, input logic signed [63:0] exp_y,
                               input bit poke, input string tag);
    int waited;
    waited = 0;
    @(negedge clk);
    x_in    = x;
    x_valid = 1'b1;
    while (!x_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 64) checkOutput({tag, " accept timeout"}, 0, 1);
    @(negedge clk);
    x_valid = 1'b0;
    for (int c = 1; c < LAT - 1; c++) begin
      if (poke && c == 3) begin
        cload = 1'b1;
        caddr = 11'd1;
        cin   = 20'd100;
      end else begin
        cload = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput({tag, " busy in run"}, busy, 1);
    checkOutput({tag, " y_valid early"}, y_valid, 0);
    @(negedge clk);
    checkOutput({tag, " y_valid"}, y_valid, 1);
    checkOutput({tag, " y"}, $signed(y), exp_y);
    @(negedge clk);
    checkOutput({tag, " y_valid pulse"}, y_valid, 0);
    checkOutput({tag, " x_ready back"}, x_ready, 1);
    checkOutput({tag, " y held"}, $signed(y), exp_y);
  endtask

  initial begin
    logic saw_valid;

    resetn  = 1'b0;
    x_in    = '0;
    x_valid = 1'b0;
    cload   = 1'b0;
    caddr   = '0;
    cin     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset y", $signed(y), 0);
    checkOutput("reset y_valid", y_valid, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset x_ready", x_ready, 1);
    resetn = 1'b1;

    // h0=3: bank0 odd entries 3, everything else 0.
    for (int b = 0; b < NBANK; b++) begin
      for (int e = 0; e < (1 << ADDR_W); e++) begin
        writeLut(b, e, (b == 0 && (e % 2) == 1) ? 3 : 0);
      end
    end
    applyStimulus(16'sd5, 15, 1'b0, "pos x=5");
    applyStimulus(-16'sd2, -6, 1'b0, "neg x=-2");

    for (int e = 1; e < (1 << ADDR_W); e += 2) writeLut(0, e, 1);
    applyStimulus(-16'sd32768, -32768, 1'b0, "sign min");
    applyStimulus(16'sd32767, 32767, 1'b0, "sign max");

    for (int e = 1; e < (1 << ADDR_W); e += 2) writeLut(0, e, 3);
    applyStimulus(16'sd1, 3, 1'b1, "drop during run");
    applyStimulus(16'sd1, 3, 1'b0, "drop after run");

    // cload beats x_valid; a constant 10 in bank7 entry0 shifts y by -10.
    @(negedge clk);
    x_in    = 16'sd1;
    x_valid = 1'b1;
    cload   = 1'b1;
    caddr   = 11'h700;
    cin     = 20'd10;
    #1;
    checkOutput("collide x_ready", x_ready, 0);
    @(negedge clk);
    cload   = 1'b0;
    x_valid = 1'b0;
    checkOutput("collide not accepted", busy, 0);
    applyStimulus(16'sd1, -7, 1'b0, "collide write applied");
    writeLut(7, 0, 0);

    // Abort a run with reset at RUN cycle 5.
    saw_valid = 1'b0;
    @(negedge clk);
    x_in    = 16'sd9;
    x_valid = 1'b1;
    @(negedge clk);
    x_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (y_valid) saw_valid = 1'b1;
    end
    resetn = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (y_valid) saw_valid = 1'b1;
    end
    resetn = 1'b1;
    repeat (LAT + 2) begin
      @(negedge clk);
      if (y_valid) saw_valid = 1'b1;
    end
    checkOutput("midrun no y_valid", saw_valid, 0);
    checkOutput("midrun y cleared", $signed(y), 0);
    checkOutput("midrun idle", busy, 0);
    applyStimulus(16'sd2, 6, 1'b0, "after midrun reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
